mux_2x1_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the `mux_2x1` datapath. It shares one output stream between two valid/ready requesters and drives the mux `sel` line. Grants are held for the length of a burst: until the `last` beat, or until `MAX_BURST` beats, whichever comes first. Selected data passes through a one-entry registered output stage toward the downstream consumer.

---
 rtl/mux_2x1_arbiter_pkg.sv | 18 +
 rtl/mux_2x1_arbiter_if.sv | 44 ++++
 rtl/mux_2x1_arbiter_mux.sv | 11 +
 rtl/mux_2x1_arbiter.sv | 139 +++++++++++++
 tb/tb_mux_2x1_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_2x1_arbiter_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Map a requester index to the state in which it owns the grant.
  function automatic state_t own_state(input logic req);
    return req ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/mux_2x1_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the downstream sink.
interface mux_2x1_arbiter_if #(
  parameter int DATA_W = 8
);

  logic              in0_valid;
  logic [DATA_W-1:0] in0_data;
  logic              in0_last;
  logic              in0_ready;

  logic              in1_valid;
  logic [DATA_W-1:0] in1_data;
  logic              in1_last;
  logic              in1_ready;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  logic              sel;
  logic              busy;

  // Environment side: drives requesters and downstream ready.
  modport master (
    output in0_valid, in0_data, in0_last,
    output in1_valid, in1_data, in1_last,
    output out_ready,
    input  in0_ready, in1_ready,
    input  out_valid, out_data, out_last,
    input  sel, busy
  );

  // Arbiter side.
  modport slave (
    input  in0_valid, in0_data, in0_last,
    input  in1_valid, in1_data, in1_last,
    input  out_ready,
    output in0_ready, in1_ready,
    output out_valid, out_data, out_last,
    output sel, busy
  );

endinterface

// File: rtl/mux_2x1_arbiter_mux.sv
// Single-bit 2:1 mux cell; the arbiter replicates it across the payload.
module mux_2x1 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sel,
  output logic o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux_2x1_arbiter.sv
// Round-robin burst arbiter in front of the mux_2x1 datapath, with a
// one-entry registered output stage.
//
//   state | meaning
//   IDLE  | no owner, arbitrate on valids using the priority pointer
//   OWN0  | requester 0 holds the grant until last or MAX_BURST beats
//   OWN1  | requester 1 holds the grant until last or MAX_BURST beats
module mux_2x1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_2x1_arbiter_if.slave bus
);

  localparam int                CNT_W       = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  LP_CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_prio;
  logic              w_prio_nxt;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [CNT_W-1:0]  w_beat_cnt_nxt;
  logic              r_sel;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;

  logic [DATA_W:0]   w_mux_a;
  logic [DATA_W:0]   w_mux_b;
  logic [DATA_W:0]   w_mux_y;

  logic              w_can_load;
  logic              w_ready0;
  logic              w_ready1;
  logic              w_xfer;
  logic              w_max_hit;
  logic              w_burst_end;
  logic              w_other_valid;

  // Payload and last flag travel together through the mux cells.
  assign w_mux_a = {bus.in0_last, bus.in0_data};
  assign w_mux_b = {bus.in1_last, bus.in1_data};

  for (genvar g = 0; g <= DATA_W; g++) begin : g_mux
    mux_2x1 u_mux (
      .i_a  (w_mux_a[g]),
      .i_b  (w_mux_b[g]),
      .i_sel(r_sel),
      .o_y  (w_mux_y[g])
    );
  end

  // The output stage can take a beat when empty or draining this cycle.
  assign w_can_load    = !r_out_valid || bus.out_ready;
  assign w_ready0      = (r_state == OWN0) && w_can_load;
  assign w_ready1      = (r_state == OWN1) && w_can_load;
  assign w_xfer        = (w_ready0 && bus.in0_valid) || (w_ready1 && bus.in1_valid);
  assign w_max_hit     = (r_beat_cnt == LP_CNT_LAST);
  assign w_burst_end   = w_xfer && (w_mux_y[DATA_W] || w_max_hit);
  assign w_other_valid = (r_state == OWN0) ? bus.in1_valid : bus.in0_valid;

  // Next-state, priority pointer and beat counter decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_prio_nxt     = r_prio;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      IDLE: begin
        w_beat_cnt_nxt = '0;
        if (bus.in0_valid && bus.in1_valid) begin
          w_state_nxt = own_state(r_prio);
        end else if (bus.in0_valid) begin
          w_state_nxt = OWN0;
        end else if (bus.in1_valid) begin
          w_state_nxt = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (w_burst_end) begin
          w_prio_nxt     = (r_state == OWN0) ? REQ1 : REQ0;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = w_other_valid ? own_state(w_prio_nxt) : IDLE;
        end else if (w_xfer) begin
          w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_beat_cnt_nxt = '0;
      end
    endcase
  end

  // State, pointer, counter and registered select; sel tracks the next owner
  // so the mux is already steered when the grant becomes effective.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_prio     <= REQ0;
      r_beat_cnt <= '0;
      r_sel      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prio     <= w_prio_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_sel      <= (w_state_nxt == OWN1);
    end
  end

  // One-entry output register; a forced rotation also marks the beat as last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_y[DATA_W-1:0];
      r_out_last  <= w_mux_y[DATA_W] || w_max_hit;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in0_ready = w_ready0;
  assign bus.in1_ready = w_ready1;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.sel       = r_sel;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Scenario bench for mux_2x1_arbiter: queue-backed requesters, a scoreboard
// of expected output beats, and per-scenario inline checks.
module tb_mux_2x1_arbiter;

  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en0   = 1'b0;
  logic en1   = 1'b0;

  int errors = 0;
  int checks = 0;

  // Beats are {last, data}.
  logic [8:0] exp_q[$];
  logic [8:0] src0_q[$];
  logic [8:0] src1_q[$];

  mux_2x1_arbiter_if #(.DATA_W(DATA_W)) bus ();

  mux_2x1_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard: every beat taken by the sink must match the next expected one.
  always @(negedge clk) begin : mon
    logic [8:0] e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_beat: unexpected beat data=%h last=%b, none expected",
                 bus.out_data, bus.out_last);
      end else begin
        e = exp_q.pop_front();
        if ({bus.out_last, bus.out_data} !== e) begin
          errors++;
          $display("FAIL out_beat: got last=%b data=%h, expected last=%b data=%h",
                   bus.out_last, bus.out_data, e[8], e[7:0]);
        end
      end
    end
  end

  task automatic drive();
    bus.in0_valid = en0 && (src0_q.size() > 0);
    bus.in0_data  = (src0_q.size() > 0) ? src0_q[0][7:0] : 8'h00;
    bus.in0_last  = (src0_q.size() > 0) ? src0_q[0][8]   : 1'b0;
    bus.in1_valid = en1 && (src1_q.size() > 0);
    bus.in1_data  = (src1_q.size() > 0) ? src1_q[0][7:0] : 8'h00;
    bus.in1_last  = (src1_q.size() > 0) ? src1_q[0][8]   : 1'b0;
  endtask

  // One clock: sample handshakes before the edge, advance sources after it.
  task automatic cycle();
    logic a0, a1;
    @(negedge clk);
    a0 = bus.in0_valid && bus.in0_ready;
    a1 = bus.in1_valid && bus.in1_ready;
    @(posedge clk);
    #1;
    if (a0) src0_q.delete(0);
    if (a1) src1_q.delete(0);
    drive();
  endtask

  task automatic drain(input int max_cyc, input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats pending after %0d cycles, expected 0",
               name, exp_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    src0_q = '{9'h1A0};
    src1_q = '{9'h1B0};
    en0 = 1'b1;
    en1 = 1'b1;
    drive();
    repeat (3) cycle();
    checks += 7;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    if (bus.out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h expected 00", bus.out_data); end
    if (bus.out_last !== 1'b0)  begin errors++; $display("FAIL rst_out_last: got %b expected 0", bus.out_last); end
    if (bus.sel !== 1'b0)       begin errors++; $display("FAIL rst_sel: got %b expected 0", bus.sel); end
    if (bus.busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    if (bus.in0_ready !== 1'b0) begin errors++; $display("FAIL rst_in0_ready: got %b expected 0", bus.in0_ready); end
    if (bus.in1_ready !== 1'b0) begin errors++; $display("FAIL rst_in1_ready: got %b expected 0", bus.in1_ready); end
    exp_q = '{9'h1A0, 9'h1B0};
    rst_n = 1'b1;
    cycle();
    checks += 4;
    if (bus.sel !== 1'b0)       begin errors++; $display("FAIL rst_first_sel: got %b expected 0", bus.sel); end
    if (bus.busy !== 1'b1)      begin errors++; $display("FAIL rst_first_busy: got %b expected 1", bus.busy); end
    if (bus.in0_ready !== 1'b1) begin errors++; $display("FAIL rst_first_in0_ready: got %b expected 1", bus.in0_ready); end
    if (bus.in1_ready !== 1'b0) begin errors++; $display("FAIL rst_first_in1_ready: got %b expected 0", bus.in1_ready); end
    drain(20, "reset");
  endtask

  task automatic test_alternating();
    logic       sel_log[$];
    logic [7:0] pat;
    int         first;
    int         last;
    pat   = 8'b11001100;
    first = -1;
    last  = -1;
    src0_q = '{9'h010, 9'h111, 9'h010, 9'h111};
    src1_q = '{9'h020, 9'h121, 9'h020, 9'h121};
    exp_q  = '{9'h010, 9'h111, 9'h020, 9'h121, 9'h010, 9'h111, 9'h020, 9'h121};
    en0 = 1'b1;
    en1 = 1'b1;
    drive();
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) begin
      cycle();
      if (bus.busy) sel_log.push_back(bus.sel);
      if (bus.out_valid) begin
        if (first < 0) first = i;
        last = i;
      end
    end
    checks++;
    if (last - first + 1 != 8) begin
      errors++;
      $display("FAIL alt_bubble: output span %0d cycles, expected 8", last - first + 1);
    end
    checks++;
    if (sel_log.size() != 8) begin
      errors++;
      $display("FAIL alt_busy_cycles: got %0d expected 8", sel_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (sel_log[i] !== pat[i]) begin
          errors++;
          $display("FAIL alt_sel[%0d]: got %b expected %b", i, sel_log[i], pat[i]);
        end
      end
    end
    drain(10, "alt");
  endtask

  task automatic test_forced_rotation();
    src0_q = '{9'h030, 9'h031, 9'h032, 9'h033, 9'h034, 9'h035, 9'h036, 9'h037};
    src1_q = '{9'h040, 9'h141};
    exp_q  = '{9'h030, 9'h031, 9'h032, 9'h133, 9'h040, 9'h141,
               9'h034, 9'h035, 9'h036, 9'h137};
    en0 = 1'b1;
    en1 = 1'b1;
    drive();
    drain(60, "forced");
    cycle();
    checks += 2;
    if (bus.busy !== 1'b0)      begin errors++; $display("FAIL forced_end_busy: got %b expected 0", bus.busy); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL forced_end_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    src0_q = '{9'h050, 9'h051, 9'h052, 9'h153};
    exp_q  = '{9'h050, 9'h051, 9'h052, 9'h153};
    en0 = 1'b1;
    en1 = 1'b0;
    drive();
    cycle();
    cycle();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks += 2;
      if (bus.in0_ready !== 1'b0) begin errors++; $display("FAIL bp_in0_ready[%0d]: got %b expected 0", i, bus.in0_ready); end
      if (bus.out_data !== 8'h50) begin errors++; $display("FAIL bp_hold_data[%0d]: got %h expected 50", i, bus.out_data); end
      cycle();
    end
    bus.out_ready = 1'b1;
    drain(20, "bp");
  endtask

  task automatic test_owner_stall();
    src0_q = '{9'h060, 9'h061, 9'h162};
    src1_q = '{9'h170};
    exp_q  = '{9'h060, 9'h061, 9'h162, 9'h170};
    en0 = 1'b1;
    en1 = 1'b0;
    drive();
    cycle();
    cycle();
    en0 = 1'b0;
    en1 = 1'b1;
    drive();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks += 2;
      if (bus.sel !== 1'b0)       begin errors++; $display("FAIL stall_sel[%0d]: got %b expected 0", i, bus.sel); end
      if (bus.in1_ready !== 1'b0) begin errors++; $display("FAIL stall_in1_ready[%0d]: got %b expected 0", i, bus.in1_ready); end
      cycle();
    end
    checks += 2;
    if (bus.sel !== 1'b0)  begin errors++; $display("FAIL stall_hold_sel: got %b expected 0", bus.sel); end
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL stall_hold_busy: got %b expected 1", bus.busy); end
    en0 = 1'b1;
    drive();
    drain(20, "stall");
  endtask

  task automatic test_reset_mid_burst();
    // A short req0 burst leaves the pointer favouring requester 1.
    src0_q = '{9'h17E};
    exp_q  = '{9'h17E};
    en0 = 1'b1;
    en1 = 1'b0;
    drive();
    drain(10, "pre_rst");
    bus.out_ready = 1'b0;
    src1_q = '{9'h090, 9'h091, 9'h192};
    en0 = 1'b0;
    en1 = 1'b1;
    drive();
    cycle();
    cycle();
    checks += 2;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", bus.out_valid); end
    if (bus.sel !== 1'b1)       begin errors++; $display("FAIL mid_pre_sel: got %b expected 1", bus.sel); end
    rst_n = 1'b0;
    src0_q = '{9'h1A1};
    src1_q = '{9'h1B1};
    en0 = 1'b1;
    en1 = 1'b1;
    drive();
    cycle();
    checks += 4;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", bus.out_valid); end
    if (bus.sel !== 1'b0)       begin errors++; $display("FAIL mid_rst_sel: got %b expected 0", bus.sel); end
    if (bus.busy !== 1'b0)      begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", bus.busy); end
    if (bus.in1_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in1_ready: got %b expected 0", bus.in1_ready); end
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    exp_q = '{9'h1A1, 9'h1B1};
    cycle();
    checks++;
    if (bus.sel !== 1'b0) begin errors++; $display("FAIL mid_regrant_sel: got %b expected 0", bus.sel); end
    drain(20, "mid_rst");
  endtask

  initial begin
    bus.out_ready = 1'b1;
    drive();
    test_reset();
    test_alternating();
    test_forced_rotation();
    test_backpressure();
    test_owner_stall();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
